cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

- Shares the single-port RAM between the instruction cache and the data cache.
- The block sits between the caches' memory-side request ports (iREN/iaddr from the icache; dREN/dWEN/daddr/dstore from the dcache) and the RAM.
- It grants one requester per transaction, latches that requester's address and data, drives the RAM until it reports ACCESS, and returns data and wait to the owner only.
- The dcache has priority; a starvation limit guarantees the icache forward progress during dcache writeback/flush bursts.

## Interface
- STARVE_LIMIT, 4: consecutive dcache grants allowed while iREN is pending before the icache is forced a grant; legal range 1..15.
- CNT_W, 16: width of the grant statistics counters.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  0 only in the cycle an icache transaction completes.
- iload  out  32  read data; valid when iwait=0.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  0 only in the cycle a dcache transaction completes.
- dload  out  32  read data; valid when dwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- mem_err  out  1  sticky; set on any ERROR completion, cleared only by reset.
- igrant_cnt  out  CNT_W  number of icache grants, wraps.
- dgrant_cnt  out  CNT_W  number of dcache grants, wraps.

## Operation
- The FSM has three states: IDLE, SERVE_I, SERVE_D.
- IDLE, no request: stay in IDLE; all RAM strobes are 0.
- IDLE, grant rule, evaluated on registered inputs at the clock edge:
  - Only iREN asserted: grant I.
  - Only dREN or dWEN asserted: grant D.
  - Both requesters asserted: grant D unless starve_cnt == STARVE_LIMIT, in which case grant I.
- On any grant:
  - Latch the owner, the address, write data (D only) and the op. If dREN and dWEN are both high, the op is a write.
  - Move to SERVE_I or SERVE_D.
  - Increment the matching grant counter, modulo 2^CNT_W.
- starve_cnt (4 bits):
  - Increments on each D grant made while iREN=1.
  - Clears on an I grant.
  - Clears in any IDLE cycle with iREN=0.
- SERVE_x:
  - ramREN/ramWEN, ramaddr and ramstore come from the latched registers, held constant for the whole transaction.
  - Stay in SERVE_x while ramstate is FREE or BUSY.
- Completion:
  - ACCESS: the owner's wait goes to 0 for exactly that cycle. On a read, the owner's load equals ramload. FSM returns to IDLE.
  - ERROR: same handshake, except the load value is 32'hBAD1BAD1; mem_err is set.
- The non-owner's wait is held at 1 throughout.
- Requester drop: if the owner deasserts its request mid-transaction, the RAM access still runs to completion. The result is discarded, the owner's wait still pulses 0, and the FSM returns to IDLE.
- Only the latched values drive the RAM. Input changes during SERVE are ignored.
- Reset values:
  - FSM = IDLE; starve_cnt = 0; both grant counters = 0; mem_err = 0.
  - iwait = dwait = 1; iload = dload = 0.
  - ramREN = ramWEN = 0; ramaddr = ramstore = 0.
- Reset asserted mid-transaction aborts immediately: RAM strobes drop asynchronously and the result is lost.

## Timing
- Grant takes 1 cycle (IDLE to SERVE); the RAM strobes are registered and assert in the first SERVE cycle.
- Minimum transaction is 2 cycles: one grant cycle, then one SERVE cycle in which ramstate=ACCESS.
- Back-to-back transactions: after a completion there is exactly one IDLE cycle before the next grant, so RAM strobes are 0 for one cycle between transactions.
- wait and load are combinational from ramstate/ramload in SERVE; all other outputs are registered.
- Counters update on the grant edge.

## Test plan
- Reset with RST=1 for 2 cycles -> iwait=dwait=1, ram strobes 0, counters 0, mem_err=0.
- Single I read: iREN=1, iaddr=0x40, ramstate ACCESS in the 1st SERVE cycle with ramload=0x1234 -> iload=0x1234 with iwait=0 for 1 cycle, then ramREN=0; igrant_cnt=1.
- Contention: iREN and dREN held continuously, D answered immediately each time, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
- D write with BUSY for 3 cycles then ACCESS; daddr/dstore changed during BUSY -> ramWEN=1 and the original address/data held for 4 cycles; dwait=0 only on the ACCESS cycle; iwait stays 1.
- ERROR completion on an I read -> iload=0xBAD1BAD1, iwait pulses 0, mem_err=1 and stays 1; the next D transaction completes normally with mem_err still 1.
- RST asserted mid SERVE_D -> ramWEN=0 in the same cycle, FSM IDLE, no dwait pulse; counter wrap checked with CNT_W=2 (the 4th grant gives 0).

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one single-port RAM between icache and dcache,
// dcache first, with a starvation limit that guarantees icache progress.
module cache_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             iREN,
    input  logic [31:0]      iaddr,
    output logic             iwait,
    output logic [31:0]      iload,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic [31:0]      daddr,
    input  logic [31:0]      dstore,
    output logic             dwait,
    output logic [31:0]      dload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic [1:0]       ramstate,
    output logic             mem_err,
    output logic [CNT_W-1:0] igrant_cnt,
    output logic [CNT_W-1:0] dgrant_cnt
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic ren_q, wen_q, err_q;
    logic [31:0] addr_q, store_q, load_v;
    logic [CNT_W-1:0] igrant_q, dgrant_q;
    logic want_d, grant_i, grant_d, done;

    assign want_d  = dREN | dWEN;
    assign grant_i = state_q == IDLE && iREN && (!want_d || starve_q == 4'(STARVE_LIMIT));
    assign grant_d = state_q == IDLE && want_d && !grant_i;
    // ACCESS (2) and ERROR (3) both end the transaction
    assign done    = state_q != IDLE && ramstate[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = grant_i ? SERVE_I : grant_d ? SERVE_D : done ? IDLE : state_q;
    end

    always_comb begin
        load_v = ramstate == 2'd3 ? 32'hBAD1BAD1 : ramload;
        iwait  = !(done && state_q == SERVE_I);
        dwait  = !(done && state_q == SERVE_D);
        iload  = iwait ? 32'd0 : load_v;
        dload  = dwait ? 32'd0 : load_v;
    end

    always_comb begin
        starve_d = grant_i ? 4'd0 :
                   (grant_d && iREN) ? starve_q + 4'd1 :
                   (state_q == IDLE && !iREN) ? 4'd0 : starve_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            igrant_q <= '0;
            dgrant_q <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            if (grant_i) begin
                ren_q    <= 1'b1;
                wen_q    <= 1'b0;
                addr_q   <= iaddr;
                igrant_q <= igrant_q + CNT_W'(1);
            end else if (grant_d) begin
                ren_q    <= !dWEN;
                wen_q    <= dWEN;
                addr_q   <= daddr;
                store_q  <= dstore;
                dgrant_q <= dgrant_q + CNT_W'(1);
            end else if (done) begin
                ren_q <= 1'b0;
                wen_q <= 1'b0;
            end
            if (done && ramstate == 2'd3) err_q <= 1'b1;
            starve_q <= starve_d;
        end
    end

    assign ramREN     = ren_q;
    assign ramWEN     = wen_q;
    assign ramaddr    = addr_q;
    assign ramstore   = store_q;
    assign mem_err    = err_q;
    assign igrant_cnt = igrant_q;
    assign dgrant_cnt = dgrant_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter.
module tb_cache_mem_arbiter;
    localparam int SL = 4;
    logic clk = 0, rst;
    logic iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0] ramstate;
    logic iwait, dwait, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [15:0] igrant_cnt, dgrant_cnt;
    logic w_iwait, w_dwait, w_ren, w_wen, w_err;
    logic [31:0] w_iload, w_dload, w_addr, w_store;
    logic [1:0] w_ig, w_dg;
    int checks = 0, fails = 0;
    int m_busy, m_owner, m_wr, m_starve, m_ig, m_dg, m_err;
    logic [31:0] m_addr, m_store;
    logic last_iw, last_dw;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.STARVE_LIMIT(SL), .CNT_W(16)) u_dut (
        .CLK(clk), .RST(rst), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err),
        .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt));

    cache_mem_arbiter #(.STARVE_LIMIT(SL), .CNT_W(2)) u_w2 (
        .CLK(clk), .RST(rst), .iREN(iREN), .iaddr(iaddr), .iwait(w_iwait), .iload(w_iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(w_dwait), .dload(w_dload),
        .ramREN(w_ren), .ramWEN(w_wen), .ramaddr(w_addr), .ramstore(w_store),
        .ramload(ramload), .ramstate(ramstate), .mem_err(w_err),
        .igrant_cnt(w_ig), .dgrant_cnt(w_dg));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_wr = 0; m_starve = 0;
        m_ig = 0; m_dg = 0; m_err = 0; m_addr = 0; m_store = 0;
    endtask

    // One clock: drive at negedge, check against the model, then advance the model
    task automatic cyc(input logic ir, input logic dr, input logic dw, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                       input logic [31:0] rl);
        logic done, wd;
        logic [31:0] ld;
        @(negedge clk);
        iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
        ramstate = rs; ramload = rl;
        #1;
        done = m_busy != 0 && rs >= 2'd2;
        ld = rs == 2'd3 ? 32'hBAD1BAD1 : rl;
        chk("iwait", iwait, !(done && m_owner == 0));
        chk("dwait", dwait, !(done && m_owner == 1));
        chk("iload", iload, (done && m_owner == 0) ? ld : 32'd0);
        chk("dload", dload, (done && m_owner == 1) ? ld : 32'd0);
        chk("ramREN", ramREN, m_busy != 0 && m_wr == 0);
        chk("ramWEN", ramWEN, m_busy != 0 && m_wr != 0);
        chk("ramaddr", ramaddr, m_addr);
        chk("ramstore", ramstore, m_store);
        chk("mem_err", mem_err, m_err != 0);
        chk("igrant_cnt", igrant_cnt, m_ig & 32'hFFFF);
        chk("dgrant_cnt", dgrant_cnt, m_dg & 32'hFFFF);
        chk("w2_igrant", w_ig, m_ig & 3);
        chk("w2_dgrant", w_dg, m_dg & 3);
        last_iw = iwait; last_dw = dwait;
        wd = dr | dw;
        if (m_busy != 0) begin
            if (rs >= 2'd2) begin
                m_busy = 0;
                if (rs == 2'd3) m_err = 1;
            end
        end else if (ir && (!wd || m_starve == SL)) begin
            m_busy = 1; m_owner = 0; m_wr = 0; m_addr = ia; m_starve = 0; m_ig++;
        end else if (wd) begin
            m_busy = 1; m_owner = 1; m_wr = dw; m_addr = da; m_store = ds; m_dg++;
            m_starve = ir ? m_starve + 1 : 0;
        end else m_starve = 0;
    endtask

    initial begin
        logic [9:0] seq;
        int ng;
        rst = 1; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
        ramstate = 0; ramload = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 1);
        chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0);
        chk("rst_icnt", igrant_cnt, 0); chk("rst_dcnt", dgrant_cnt, 0);
        chk("rst_err", mem_err, 0); chk("rst_iload", iload, 0);
        rst = 0;

        cyc(1, 0, 0, 32'h40, 0, 0, 2'd0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'd2, 32'h1234);
        chk("iread_iload", iload, 32'h1234); chk("iread_iwait", iwait, 0);
        chk("iread_addr", ramaddr, 32'h40);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
        chk("iread_ren_off", ramREN, 0); chk("iread_icnt", igrant_cnt, 1);

        seq = 0; ng = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1, 1, 0, $urandom, $urandom, $urandom, 2'd2, $urandom);
            if (!last_iw || !last_dw) begin
                seq = {seq[8:0], !last_iw};
                ng++;
            end
        end
        chk("grant_seq", {22'd0, seq}, 32'h021);
        chk("grant_n", ng, 10);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);

        cyc(0, 0, 1, 0, 32'h100, 32'hCAFE, 2'd0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 0, $urandom, $urandom, k < 3 ? 2'd1 : 2'd2, 0);
            chk("dwr_wen", ramWEN, 1); chk("dwr_addr", ramaddr, 32'h100);
            chk("dwr_store", ramstore, 32'hCAFE); chk("dwr_dwait", dwait, k < 3);
            chk("dwr_iwait", iwait, 1);
        end

        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
        cyc(1, 0, 0, 32'h80, 0, 0, 2'd0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'd3, 32'h55);
        chk("err_iload", iload, 32'hBAD1BAD1); chk("err_iwait", iwait, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
        chk("err_sticky", mem_err, 1);
        cyc(0, 1, 0, 0, 32'h90, 0, 2'd0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'd2, 32'hABCD);
        chk("err_dload", dload, 32'hABCD); chk("err_dwait", dwait, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
        chk("err_still", mem_err, 1);

        cyc(0, 0, 1, 0, 32'h200, 32'h77, 2'd0, 0);
        @(negedge clk);
        ramstate = 2'd1;
        #1 chk("mid_wen_pre", ramWEN, 1);
        rst = 1; ramstate = 2'd2;
        #1;
        chk("mid_wen_drop", ramWEN, 0); chk("mid_dwait", dwait, 1);
        @(negedge clk);
        iREN = 0; dREN = 0; dWEN = 0; ramstate = 0; rst = 0;
        model_reset();

        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, $urandom, 0, 0, 2'd0, 0);
            cyc(0, 0, 0, 0, 0, 0, 2'd2, $urandom);
        end
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
        chk("wrap_w2", w_ig, 0); chk("wrap_dut", igrant_cnt, 4);

        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 9);
            cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
                $urandom, $urandom, $urandom,
                r < 2 ? 2'd0 : r < 5 ? 2'd1 : r < 9 ? 2'd2 : 2'd3, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
